// File: rtl/tl_pkg.sv
// tl_pkg: shared FSM states, default sizes and clog2 helper for the transfer-layer router
package tl_pkg;
  typedef enum logic [1:0] {ST_CFG, ST_INIT, ST_ACTIVE} state_t;
  localparam int DEF_DW    = 12;
  localparam int DEF_NCH   = 4;
  localparam int DEF_DEPTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO with registered pop data, combinational head peek and occupancy
module fifo_sync
  import tl_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [DW-1:0] peek_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   occ_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   occ_q;
  logic          wr, rd;
  assign full_o  = occ_q == (AW+1)'(DEPTH);
  assign empty_o = occ_q == '0;
  assign occ_o   = occ_q;
  assign peek_o  = mem_q[rp_q];
  assign dout_o  = dout_q;
  assign wr      = push_i && !full_o;
  assign rd      = pop_i && !empty_o;
  // storage, pointers, occupancy and the registered read port; push on full and pop on empty are ignored
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
      dout_q <= '0;
    end else begin
      if (wr) mem_q[wp_q] <= din_i;
      if (rd) dout_q <= mem_q[rp_q];
      wp_q  <= wp_q + AW'(wr);
      rp_q  <= rp_q + AW'(rd);
      occ_q <= occ_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/tl_router_nch.sv
// tl_router_nch: input FIFO demultiplexed by destination field into NCH threshold-flagged output FIFOs; TL_ERR_FLAGS_EN adds sticky errFlags
module tl_router_nch
  import tl_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int NCH   = DEF_NCH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int CNT_W = 5,
  localparam int AW    = clog2(DEPTH),
  localparam int DSTW  = clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [AW:0]       umbral_bajo,
  input  logic [AW:0]       umbral_alto,
  input  logic              pushIn,
  input  logic [DW-1:0]     dataIn,
  output logic              inFull,
  input  logic [NCH-1:0]    popOut,
  output logic [NCH*DW-1:0] dataOut,
  output logic [NCH-1:0]    outEmpty,
  output logic [NCH-1:0]    almostEmpty,
  output logic [NCH-1:0]    almostFull,
  output logic              active,
  input  logic              req,
  input  logic [DSTW:0]     idx,
  output logic              counterValid,
  output logic [CNT_W-1:0]  counterOut
`ifdef TL_ERR_FLAGS_EN
  ,
  output logic [NCH:0]      errFlags
`endif
);
  state_t           state_q, state_d;
  logic [AW:0]      lo_q, hi_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic             cv_q;
  logic [CNT_W-1:0] co_q;
  logic             in_empty, xfer;
  logic [DW-1:0]    head, unused_in_dout;
  logic [AW:0]      unused_in_occ;
  logic [DSTW-1:0]  dst;
  logic [NCH-1:0]   out_full, vpop;
  logic [AW:0]      occ [NCH];
  logic [DW-1:0]    unused_peek [NCH];

  fifo_sync #(.DW(DW), .DEPTH(DEPTH)) u_in (
    .clk(clk), .reset(reset), .push_i(pushIn), .din_i(dataIn), .pop_i(xfer),
    .dout_o(unused_in_dout), .peek_o(head), .full_o(inFull), .empty_o(in_empty), .occ_o(unused_in_occ)
  );

  assign dst    = head[DW-1 -: DSTW];
  assign xfer   = state_q == ST_ACTIVE && !in_empty && !almostFull[dst] && !out_full[dst];
  assign active = state_q == ST_ACTIVE;
  assign vpop   = popOut & ~outEmpty;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      fifo_sync #(.DW(DW), .DEPTH(DEPTH)) u_out (
        .clk(clk), .reset(reset), .push_i(xfer && dst == DSTW'(k)), .din_i(head), .pop_i(popOut[k]),
        .dout_o(dataOut[k*DW +: DW]), .peek_o(unused_peek[k]), .full_o(out_full[k]), .empty_o(outEmpty[k]), .occ_o(occ[k])
      );
      assign almostEmpty[k] = occ[k] <= lo_q;
      assign almostFull[k]  = occ[k] >= hi_q;
    end
  endgenerate

  // next state: CFG and ACTIVE enter INIT on init, INIT always falls through to ACTIVE
  always_comb state_d = state_q == ST_INIT ? ST_ACTIVE : init ? ST_INIT : state_q;

  // state register; thresholds are captured on the init that starts an INIT cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_CFG;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (init && state_q != ST_INIT) begin
        lo_q <= umbral_bajo;
        hi_q <= umbral_alto;
      end
    end

  // delivered-word counters, wrapping, cleared during the INIT cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    else for (int i = 0; i < NCH; i++) cnt_q[i] <= state_q == ST_INIT ? '0 : cnt_q[i] + CNT_W'(vpop[i]);

  // counter read port: one-cycle strobe, pre-increment value, out-of-range index reads zero
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cv_q <= 1'b0;
      co_q <= '0;
    end else begin
      cv_q <= req;
      if (req) co_q <= idx[DSTW] ? '0 : cnt_q[idx[DSTW-1:0]];
    end

  assign counterValid = cv_q;
  assign counterOut   = co_q;

`ifdef TL_ERR_FLAGS_EN
  logic [NCH:0] err_q;
  // sticky input-overflow (top bit) and per-channel pop-on-empty flags, cleared by init
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= '0;
    else err_q <= init ? '0 : err_q | {pushIn && inFull, popOut & outEmpty};
  assign errFlags = err_q;
`endif
endmodule

// File: tb/tb_tl_router_nch.sv
// tb_tl_router_nch: vector table, corner sequences and random traffic against a queue-based reference model
module tb_tl_router_nch;
  localparam int DW = 12, NCH = 4, DEPTH = 8, CNT_W = 5, DSTW = 2;

  logic              clk = 1'b0;
  logic              reset, init, pushIn, req;
  logic [3:0]        umbral_bajo, umbral_alto;
  logic [DW-1:0]     dataIn;
  logic [NCH-1:0]    popOut;
  logic [DSTW:0]     idx;
  logic              inFull, active, counterValid;
  logic [NCH*DW-1:0] dataOut;
  logic [NCH-1:0]    outEmpty, almostEmpty, almostFull;
  logic [CNT_W-1:0]  counterOut;
`ifdef TL_ERR_FLAGS_EN
  logic [NCH:0]      errFlags;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tl_router_nch #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .pushIn(pushIn), .dataIn(dataIn), .inFull(inFull), .popOut(popOut), .dataOut(dataOut),
    .outEmpty(outEmpty), .almostEmpty(almostEmpty), .almostFull(almostFull), .active(active),
    .req(req), .idx(idx), .counterValid(counterValid), .counterOut(counterOut)
`ifdef TL_ERR_FLAGS_EN
    , .errFlags(errFlags)
`endif
  );

  int            mode, lo_m, hi_m, co_m;
  int            cnt_m [NCH];
  bit            cv_m;
  logic [DW-1:0] inq [$];
  logic [DW-1:0] outq [NCH][$];
  logic [DW-1:0] dout_m [NCH];
  logic [NCH:0]  err_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; lo_m = 0; hi_m = 0; cv_m = 0; co_m = 0; err_m = '0;
    inq.delete();
    for (int k = 0; k < NCH; k++) begin
      outq[k].delete();
      dout_m[k] = '0;
      cnt_m[k] = 0;
    end
  endtask

  task automatic model_step();
    bit infull_pre, xfer;
    int d;
    logic [NCH:0] e;
    infull_pre = inq.size() == DEPTH;
    xfer = 0;
    d = 0;
    if (mode == 2 && inq.size() > 0) begin
      d = int'(inq[0] >> (DW - DSTW));
      xfer = outq[d].size() < hi_m && outq[d].size() < DEPTH;
    end
    cv_m = req;
    if (req) co_m = (idx >= NCH) ? 0 : cnt_m[idx];
    e = err_m;
    if (pushIn && infull_pre) e[NCH] = 1'b1;
    for (int k = 0; k < NCH; k++) if (popOut[k] && outq[k].size() == 0) e[k] = 1'b1;
    err_m = init ? '0 : e;
    for (int k = 0; k < NCH; k++)
      if (popOut[k] && outq[k].size() > 0) begin
        dout_m[k] = outq[k].pop_front();
        cnt_m[k] = (cnt_m[k] + 1) % (1 << CNT_W);
      end
    if (mode == 1) for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
    if (xfer) outq[d].push_back(inq.pop_front());
    if (pushIn && !infull_pre) inq.push_back(dataIn);
    if (mode == 1) mode = 2;
    else if (init) begin
      lo_m = umbral_bajo;
      hi_m = umbral_alto;
      mode = 1;
    end
  endtask

  task automatic compare_model();
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0] e, ae, af;
    for (int k = 0; k < NCH; k++) begin
      e[k] = outq[k].size() == 0;
      ae[k] = outq[k].size() <= lo_m;
      af[k] = outq[k].size() >= hi_m;
      d[k*DW +: DW] = dout_m[k];
    end
    check("m_inFull", inFull, inq.size() == DEPTH);
    check("m_outEmpty", outEmpty, e);
    check("m_almostEmpty", almostEmpty, ae);
    check("m_almostFull", almostFull, af);
    check("m_active", active, mode == 2);
    check("m_dataOut", dataOut, d);
    check("m_counterValid", counterValid, cv_m);
    check("m_counterOut", counterOut, co_m);
`ifdef TL_ERR_FLAGS_EN
    check("m_errFlags", errFlags, err_m);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    init = 0; pushIn = 0; dataIn = '0; popOut = '0; req = 0; idx = '0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    model_reset();
    #1;
    check("rst_outEmpty", outEmpty, 4'hF);
    check("rst_almostEmpty", almostEmpty, 4'hF);
    check("rst_almostFull", almostFull, 4'hF);
    check("rst_inFull", inFull, 0);
    check("rst_active", active, 0);
    check("rst_dataOut", dataOut, 0);
    check("rst_counterValid", counterValid, 0);
    check("rst_counterOut", counterOut, 0);
    #2;
    reset = 0;
  endtask

  typedef struct {
    logic        init;
    logic        push;
    logic [11:0] din;
    logic [3:0]  pop;
    logic        rq;
    logic [2:0]  ix;
    logic [3:0]  oe;
    logic        act;
    logic [3:0]  af;
    logic [47:0] dout;
    logic        cv;
    logic [4:0]  co;
  } vec_t;

  vec_t tv [10];
  localparam logic [47:0] ROUTED = 48'hFFF_AFF_5FF_00F;

  initial begin
    idle_inputs();
    umbral_bajo = 4'd0;
    umbral_alto = 4'd0;
    reset = 1;
    model_reset();
    #6;
    do_reset();

    tv[0] = '{1'b1, 1'b0, 12'h000, 4'h0, 1'b0, 3'd0, 4'hF, 1'b0, 4'h0, 48'h0,  1'b0, 5'd0};
    tv[1] = '{1'b0, 1'b1, 12'h00F, 4'h0, 1'b0, 3'd0, 4'hF, 1'b1, 4'h0, 48'h0,  1'b0, 5'd0};
    tv[2] = '{1'b0, 1'b1, 12'h5FF, 4'h0, 1'b0, 3'd0, 4'hE, 1'b1, 4'h0, 48'h0,  1'b0, 5'd0};
    tv[3] = '{1'b0, 1'b1, 12'hAFF, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 4'h0, 48'h0,  1'b0, 5'd0};
    tv[4] = '{1'b0, 1'b1, 12'hFFF, 4'h0, 1'b0, 3'd0, 4'h8, 1'b1, 4'h0, 48'h0,  1'b0, 5'd0};
    tv[5] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 3'd0, 4'h0, 1'b1, 4'h0, 48'h0,  1'b0, 5'd0};
    tv[6] = '{1'b0, 1'b0, 12'h000, 4'hF, 1'b0, 3'd0, 4'hF, 1'b1, 4'h0, ROUTED, 1'b0, 5'd0};
    tv[7] = '{1'b0, 1'b0, 12'h000, 4'h1, 1'b1, 3'd5, 4'hF, 1'b1, 4'h0, ROUTED, 1'b1, 5'd0};
    tv[8] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 3'd2, 4'hF, 1'b1, 4'h0, ROUTED, 1'b1, 5'd1};
    tv[9] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 3'd0, 4'hF, 1'b1, 4'h0, ROUTED, 1'b0, 5'd1};
    umbral_bajo = 4'd1;
    umbral_alto = 4'd7;
    for (int i = 0; i < 10; i++) begin
      init = tv[i].init; pushIn = tv[i].push; dataIn = tv[i].din;
      popOut = tv[i].pop; req = tv[i].rq; idx = tv[i].ix;
      tick();
      check($sformatf("tv%0d_outEmpty", i), outEmpty, tv[i].oe);
      check($sformatf("tv%0d_active", i), active, tv[i].act);
      check($sformatf("tv%0d_almostFull", i), almostFull, tv[i].af);
      check($sformatf("tv%0d_dataOut", i), dataOut, tv[i].dout);
      check($sformatf("tv%0d_counterValid", i), counterValid, tv[i].cv);
      check($sformatf("tv%0d_counterOut", i), counterOut, tv[i].co);
    end
    idle_inputs();

    pushIn = 1; dataIn = 12'h4A5;
    tick();
    check("lat_edgeN_empty", outEmpty[1], 1);
    idle_inputs();
    tick();
    check("lat_edgeN1_visible", outEmpty[1], 0);
    popOut = 4'h2;
    tick();
    check("lat_pop_data", dataOut[23:12], 12'h4A5);
    idle_inputs();

    do_reset();
    umbral_bajo = 4'd0;
    umbral_alto = 4'd3;
    init = 1;
    tick();
    init = 0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      pushIn = 1;
      dataIn = (i == 6) ? 12'h4AA : DW'(i);
      tick();
      if (i == 3) check("bp_af_two_words", almostFull[0], 0);
      if (i == 4) check("bp_af_three_words", almostFull[0], 1);
    end
    idle_inputs();
    repeat (3) tick();
    check("bp_af_held", almostFull[0], 1);
    check("bp_hol_ch1", outEmpty[1], 1);
    check("bp_inFull", inFull, 0);
    popOut = 4'h1;
    tick();
    check("bp_pop1_data", dataOut[11:0], 12'h001);
    check("bp_pop1_af", almostFull[0], 0);
    popOut = 4'h0;
    tick();
    check("bp_refill_af", almostFull[0], 1);
    repeat (3) tick();
    check("bp_hol_still", outEmpty[1], 1);
    popOut = 4'h1;
    tick();
    check("bp_pop2_data", dataOut[11:0], 12'h002);
    popOut = 4'h0;
    repeat (2) tick();
    check("bp_ch1_arrived", outEmpty[1], 0);
    for (int i = 3; i <= 5; i++) begin
      popOut = 4'h1;
      tick();
      check("bp_order_ch0", dataOut[11:0], DW'(i));
    end
    popOut = 4'h2;
    tick();
    check("bp_ch1_data", dataOut[23:12], 12'h4AA);
    idle_inputs();

    do_reset();
    for (int i = 0; i < 9; i++) begin
      pushIn = 1;
      dataIn = DW'(12'hC00 + i);
      tick();
      if (i == 6) check("full_after7", inFull, 0);
      if (i >= 7) check("full_after8", inFull, 1);
    end
    idle_inputs();
    umbral_alto = 4'd15;
    init = 1;
    tick();
    init = 0;
    repeat (10) tick();
    check("full_ch3_filled", outEmpty[3], 0);
    check("full_in_drained", inFull, 0);
    pushIn = 1; dataIn = 12'hC09;
    tick();
    pushIn = 0;
    repeat (3) tick();
    check("full_no_backpressure_flag", almostFull[3], 0);
    for (int i = 0; i < 9; i++) begin
      popOut = 4'h8;
      tick();
      check("full_pop_order", dataOut[47:36], (i < 8) ? DW'(12'hC00 + i) : 12'hC09);
    end
    tick();
    check("empty_pop_hold", dataOut[47:36], 12'hC09);
    check("empty_pop_flag", outEmpty[3], 1);
    idle_inputs();

    do_reset();
    init = 1;
    tick();
    init = 0;
    tick();
    for (int i = 0; i < 33; i++) begin
      pushIn = 1; dataIn = DW'(12'h800 | i);
      tick();
      pushIn = 0;
      tick();
      popOut = 4'h4;
      tick();
      popOut = 4'h0;
    end
    req = 1; idx = 3'd2;
    tick();
    check("cnt_wrap_valid", counterValid, 1);
    check("cnt_wrap_value", counterOut, 1);
    idx = 3'd5;
    tick();
    check("cnt_oor_valid", counterValid, 1);
    check("cnt_oor_value", counterOut, 0);
    req = 0;
    tick();
    check("cnt_idle_valid", counterValid, 0);

    pushIn = 1; dataIn = 12'h411;
    tick();
    dataIn = 12'h422; init = 1;
    tick();
    check("reinit_inactive", active, 0);
    init = 0; dataIn = 12'h433;
    tick();
    check("reinit_active", active, 1);
    pushIn = 0; req = 1; idx = 3'd2;
    tick();
    check("reinit_cnt_cleared", counterOut, 0);
    req = 0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      popOut = 4'h2;
      tick();
      check("reinit_preserved", dataOut[23:12], DW'(12'h400 + 12'h11 * i));
    end
    idle_inputs();

    pushIn = 1;
    for (int i = 0; i < 3; i++) begin
      dataIn = DW'(12'h8C0 + i);
      tick();
    end
    do_reset();
    idle_inputs();
    init = 1;
    tick();
    init = 0;
    tick();
    for (int i = 0; i < NCH; i++) begin
      req = 1; idx = DSTW'(i);
      tick();
      check("rst_counter_zero", counterOut, 0);
    end
    idle_inputs();

    for (int r = 0; r < 3; r++) begin
      do_reset();
      umbral_bajo = 4'($urandom_range(0, 8));
      umbral_alto = 4'($urandom_range(1, 15));
      init = 1;
      tick();
      for (int c = 0; c < 500; c++) begin
        pushIn = ($urandom % 3) != 0;
        dataIn = DW'($urandom);
        popOut = NCH'($urandom);
        req = ($urandom % 4) == 0;
        idx = 3'($urandom);
        init = ($urandom % 97) == 0;
        if (init) begin
          umbral_bajo = 4'($urandom_range(0, 8));
          umbral_alto = 4'($urandom_range(1, 15));
        end
        tick();
      end
      idle_inputs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
